// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch predictor: counter encodings,
// elaboration-time log2 and the sequential PC increment.
package bp_pkg;

  localparam int unsigned PC_STEP = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Weakly not-taken: 0b01..1
  function automatic logic [31:0] ctr_weak_nt(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Weakly taken: 0b10..0
  function automatic logic [31:0] ctr_weak_t(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup (IF stage), update (ID stage) and performance signals of the predictor.
interface branch_predictor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned GHR_W  = 0,
  parameter int unsigned PERF_W = 16
);
  localparam int unsigned HIST_W = (GHR_W > 0) ? GHR_W : 1;

  logic [ADDR_W-1:0] lk_pc_i;
  logic              lk_hit_o;
  logic              lk_taken_o;
  logic [ADDR_W-1:0] lk_target_o;
  logic [HIST_W-1:0] lk_ghr_o;

  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic [HIST_W-1:0] upd_ghr_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_mispred_i;

  logic [PERF_W-1:0] perf_branches_o;
  logic [PERF_W-1:0] perf_mispred_o;

  modport master (
    output lk_pc_i, upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_target_i, upd_mispred_i,
    input  lk_hit_o, lk_taken_o, lk_target_o, lk_ghr_o, perf_branches_o, perf_mispred_o
  );

  modport slave (
    input  lk_pc_i, upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_target_i, upd_mispred_i,
    output lk_hit_o, lk_taken_o, lk_target_o, lk_ghr_o, perf_branches_o, perf_mispred_o
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter with synchronous reset and a load value used on allocation.
module bp_sat_ctr #(
  parameter int unsigned       CTR_W    = 2,
  parameter logic [CTR_W-1:0]  RST_VAL  = '0,
  parameter logic [CTR_W-1:0]  LOAD_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (inc && (count != '1)) begin
      count <= count + CTR_W'(1);
    end else if (dec && (count != '0)) begin
      count <= count - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters and optional gshare indexing;
// combinational lookup for IF, training from the resolved branch in ID.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned GHR_W   = 0,
  parameter int unsigned PERF_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W  = clog2(ENTRIES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;
  localparam int unsigned HIST_W = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_t(CTR_W));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr      [ENTRIES];
  logic [HIST_W-1:0]  ghr_q;
  logic [PERF_W-1:0]  perf_br_q;
  logic [PERF_W-1:0]  perf_mp_q;

  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] pc,
                                                input logic [HIST_W-1:0] hist);
    logic [IDX_W-1:0] h;
    h = (GHR_W > 0) ? IDX_W'(hist) : '0;
    return pc[IDX_W+1:2] ^ h;
  endfunction

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, lk_taken, upd_hit, upd_write;

  assign lk_idx   = index_of(bp.lk_pc_i, ghr_q);
  assign lk_tag   = bp.lk_pc_i[ADDR_W-1:IDX_W+2];
  // Gated by reset so the lookup reads as empty even before the clearing edge.
  assign lk_hit   = !rst_i && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr[lk_idx][CTR_W-1];

  assign bp.lk_hit_o        = lk_hit;
  assign bp.lk_taken_o      = lk_taken;
  assign bp.lk_target_o     = lk_taken ? target_q[lk_idx] : bp.lk_pc_i + ADDR_W'(PC_STEP);
  assign bp.lk_ghr_o        = rst_i ? '0 : ghr_q;
  assign bp.perf_branches_o = rst_i ? '0 : perf_br_q;
  assign bp.perf_mispred_o  = rst_i ? '0 : perf_mp_q;

  assign upd_idx   = index_of(bp.upd_pc_i, bp.upd_ghr_i);
  assign upd_tag   = bp.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_write = bp.upd_valid_i && bp.upd_taken_i;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic sel;
    assign sel = bp.upd_valid_i && (upd_idx == IDX_W'(i));
    bp_sat_ctr #(
      .CTR_W    (CTR_W),
      .RST_VAL  (CTR_WNT),
      .LOAD_VAL (CTR_WT)
    ) u_ctr (
      .clk   (clk_i),
      .rst   (rst_i),
      .load  (sel && !upd_hit && bp.upd_taken_i),
      .inc   (sel && upd_hit && bp.upd_taken_i),
      .dec   (sel && upd_hit && !bp.upd_taken_i),
      .count (ctr[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (upd_write) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Taken hits and taken-miss allocations write the same tag/target fields.
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_write) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= bp.upd_target_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else if (bp.upd_valid_i) begin
      if (perf_br_q != '1) perf_br_q <= perf_br_q + PERF_W'(1);
      if (bp.upd_mispred_i && (perf_mp_q != '1)) perf_mp_q <= perf_mp_q + PERF_W'(1);
    end
  end

  if (GHR_W > 0) begin : g_ghr
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ghr_q <= '0;
      end else if (bp.upd_valid_i) begin
        ghr_q <= HIST_W'({ghr_q, bp.upd_taken_i});
      end
    end
  end else begin : g_no_ghr
    assign ghr_q = '0;
  end

  logic unused_bits;
  assign unused_bits = ^{bp.lk_pc_i[1:0], bp.upd_pc_i[1:0]};

endmodule
